// File: rtl/fcmp_pipe.sv
// Two-stage, multi-lane floating-point compare pipeline (EQ/LE/LT) with valid/ready handshaking.
// Define FCMP_PIPE_MINMAX_EN to add the MIN/MAX datapath; without it those op codes are reserved.
`timescale 1ns/1ps

module fcmp_pipe #(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24,
    parameter int LANES     = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [2:0]                           op_i,
    input  logic [LANES*(EXPWIDTH+PRECISION)-1:0] a_i,
    input  logic [LANES*(EXPWIDTH+PRECISION)-1:0] b_i,
    input  logic [LANES-1:0]                     lane_mask_i,
    input  logic [TAG_WIDTH-1:0]                 tag_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [LANES*(EXPWIDTH+PRECISION)-1:0] result_o,
    output logic [4:0]                           fflags_o,
    output logic [TAG_WIDTH-1:0]                 tag_o
);

    localparam int FW = EXPWIDTH + PRECISION;  // sign + exponent + stored significand
    localparam int MW = PRECISION - 1;         // stored significand width
    localparam int DW = LANES * FW;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_LE  = 3'b001,
        OP_LT  = 3'b010,
        OP_MIN = 3'b011,
        OP_MAX = 3'b100
    } op_e;

    function automatic logic is_nan(input logic [FW-1:0] x);
        return (&x[FW-2:MW]) && (|x[MW-1:0]);
    endfunction

    function automatic logic is_snan(input logic [FW-1:0] x);
        return is_nan(x) && !x[MW-1];
    endfunction

    // ---------------- handshake ----------------
    logic s1_valid_q, s2_valid_q;
    logic s2_adv, accept;

    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s2_adv;
    assign accept     = in_valid_i && in_ready_o;

    // ---------------- stage 1: classify and subtract magnitudes ----------------
    logic [LANES-1:0]          s1_nan_a_d, s1_nan_b_d, s1_snan_d, s1_zero_d, s1_sa_d, s1_sb_d;
    logic [LANES-1:0][FW-1:0]  s1_diff_d;

    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        s1_nan_a_d = '0;
        s1_nan_b_d = '0;
        s1_snan_d  = '0;
        s1_zero_d  = '0;
        s1_sa_d    = '0;
        s1_sb_d    = '0;
        s1_diff_d  = '0;
        for (int l = 0; l < LANES; l++) begin
            s1_nan_a_d[l] = is_nan(a_i[l*FW +: FW]);
            s1_nan_b_d[l] = is_nan(b_i[l*FW +: FW]);
            s1_snan_d[l]  = is_snan(a_i[l*FW +: FW]) || is_snan(b_i[l*FW +: FW]);
            s1_zero_d[l]  = ~|a_i[l*FW +: FW-1] && ~|b_i[l*FW +: FW-1];
            s1_sa_d[l]    = a_i[l*FW + FW-1];
            s1_sb_d[l]    = b_i[l*FW + FW-1];
            // Top bit is the borrow (|a| < |b|); all-zero means equal magnitudes.
            s1_diff_d[l]  = {1'b0, a_i[l*FW +: FW-1]} - {1'b0, b_i[l*FW +: FW-1]};
        end
    end

    logic [LANES-1:0]          s1_nan_a_q, s1_nan_b_q, s1_snan_q, s1_zero_q, s1_sa_q, s1_sb_q;
    logic [LANES-1:0][FW-1:0]  s1_diff_q;
    logic [LANES-1:0]          s1_mask_q;
    op_e                       s1_op_q;
    logic [TAG_WIDTH-1:0]      s1_tag_q;
`ifdef FCMP_PIPE_MINMAX_EN
    logic [DW-1:0]             s1_a_q, s1_b_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) s1_valid_q <= 1'b0;
        else if (in_ready_o) s1_valid_q <= in_valid_i;
    end

    // NOTE: payload registers carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_nan_a_q <= s1_nan_a_d;
            s1_nan_b_q <= s1_nan_b_d;
            s1_snan_q  <= s1_snan_d;
            s1_zero_q  <= s1_zero_d;
            s1_sa_q    <= s1_sa_d;
            s1_sb_q    <= s1_sb_d;
            s1_diff_q  <= s1_diff_d;
            s1_mask_q  <= lane_mask_i;
            s1_op_q    <= op_e'(op_i);
            s1_tag_q   <= tag_i;
`ifdef FCMP_PIPE_MINMAX_EN
            s1_a_q     <= a_i;
            s1_b_q     <= b_i;
`endif
        end
    end

    // ---------------- stage 2: select result and flags ----------------
`ifdef FCMP_PIPE_MINMAX_EN
    localparam logic [FW-1:0] CANON_NAN = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(MW-1){1'b0}}};
`endif

    logic [DW-1:0] s2_result_d;
    logic [4:0]    s2_fflags_d;

    always_comb begin
        logic          borrow, mag_eq, any_nan, lt_tot, eq_v, lt_v, inv;
        logic [FW-1:0] lr;
`ifdef FCMP_PIPE_MINMAX_EN
        logic [FW-1:0] la, lb;
        la = '0;
        lb = '0;
`endif
        borrow      = 1'b0;
        mag_eq      = 1'b0;
        any_nan     = 1'b0;
        lt_tot      = 1'b0;
        eq_v        = 1'b0;
        lt_v        = 1'b0;
        inv         = 1'b0;
        lr          = '0;
        s2_result_d = '0;
        s2_fflags_d = '0;
        for (int l = 0; l < LANES; l++) begin
            borrow  = s1_diff_q[l][FW-1];
            mag_eq  = ~|s1_diff_q[l];
            any_nan = s1_nan_a_q[l] || s1_nan_b_q[l];
            // Sign-magnitude total order in which -0 sorts below +0.
            lt_tot  = (s1_sa_q[l] != s1_sb_q[l]) ? s1_sa_q[l]
                    : (s1_sa_q[l] ? (!borrow && !mag_eq) : borrow);
            eq_v    = s1_zero_q[l] || ((s1_sa_q[l] == s1_sb_q[l]) && mag_eq);
            lt_v    = lt_tot && !s1_zero_q[l];
            lr      = '0;
            inv     = 1'b0;
`ifdef FCMP_PIPE_MINMAX_EN
            la      = s1_a_q[l*FW +: FW];
            lb      = s1_b_q[l*FW +: FW];
`endif
            case (s1_op_q)
                OP_EQ: begin
                    lr[0] = !any_nan && eq_v;
                    inv   = s1_snan_q[l];
                end
                OP_LE: begin
                    lr[0] = !any_nan && (lt_v || eq_v);
                    inv   = any_nan;
                end
                OP_LT: begin
                    lr[0] = !any_nan && lt_v;
                    inv   = any_nan;
                end
`ifdef FCMP_PIPE_MINMAX_EN
                OP_MIN, OP_MAX: begin
                    if (s1_nan_a_q[l] && s1_nan_b_q[l]) lr = CANON_NAN;
                    else if (s1_nan_a_q[l])             lr = lb;
                    else if (s1_nan_b_q[l])             lr = la;
                    else                                lr = ((s1_op_q == OP_MIN) == lt_tot) ? la : lb;
                    inv = s1_snan_q[l];
                end
`endif
                default: begin
                    lr  = '0;
                    inv = 1'b0;
                end
            endcase
            if (!s1_mask_q[l]) begin
                lr  = '0;
                inv = 1'b0;
            end
            s2_result_d[l*FW +: FW] = lr;
            s2_fflags_d[4]          = s2_fflags_d[4] || inv;
        end
    end

    logic [DW-1:0]        s2_result_q;
    logic [4:0]           s2_fflags_q;
    logic [TAG_WIDTH-1:0] s2_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_fflags_q <= '0;
            s2_tag_q    <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_fflags_q <= s2_fflags_d;
                s2_tag_q    <= s1_tag_q;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign result_o    = s2_result_q;
    assign fflags_o    = s2_fflags_q;
    assign tag_o       = s2_tag_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe: a driver pushes expected responses, a monitor pops and compares.
// MIN/MAX expectations follow FCMP_PIPE_MINMAX_EN as the RTL does.
`timescale 1ns/1ps

module tb_fcmp_pipe;

    localparam int TW = 8;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i, in_ready_o;
    logic [2:0]    op_i;
    logic [DW-1:0] a_i, b_i;
    logic [3:0]    lane_mask_i;
    logic [TW-1:0] tag_i;
    logic          out_valid_o, out_ready_i;
    logic [DW-1:0] result_o;
    logic [4:0]    fflags_o;
    logic [TW-1:0] tag_o;

    fcmp_pipe #(.EXPWIDTH(8), .PRECISION(24), .LANES(4), .TAG_WIDTH(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .lane_mask_i (lane_mask_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .fflags_o    (fflags_o),
        .tag_o       (tag_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        logic [4:0]    ff;
        logic [TW-1:0] tag;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Drives one request (called at a negedge) and returns at the negedge after it is accepted.
    task automatic send(input logic [2:0] op_v, input logic [DW-1:0] a_v, input logic [DW-1:0] b_v,
                        input logic [3:0] m, input logic [TW-1:0] t, input logic [DW-1:0] r,
                        input logic [4:0] ff, input bit lat);
        exp_t e;
        bit   acc = 1'b0;
        int   budget = 0;
        op_i = op_v; a_i = a_v; b_i = b_v; lane_mask_i = m; tag_i = t; in_valid_i = 1'b1;
        e.res = r; e.ff = ff; e.tag = t; e.lat = lat; e.cyc = 0;
        while (!acc) begin
            if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready_o;
            if (acc) begin
                e.cyc = cyc;
                sb_q.push_back(e);
            end
            @(negedge clk);
            budget++;
            if (!acc && budget > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout: tag %h never accepted", t);
                acc = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid_i  = 1'b0;
        rand_ready  = 1'b0;
        out_ready_i = 1'b1;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: samples 2 ns after each negedge, after the driver has settled its inputs.
    initial begin
        exp_t          e;
        bit            stalled = 1'b0;
        logic [DW-1:0] h_res;
        logic [4:0]    h_ff;
        logic [TW-1:0] h_tag;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid_held", DW'(out_valid_o), DW'(1));
                    if (out_valid_o) begin
                        check("stall_result_held", result_o, h_res);
                        check("stall_fflags_held", DW'(fflags_o), DW'(h_ff));
                        check("stall_tag_held", DW'(tag_o), DW'(h_tag));
                    end
                end
                stalled = 1'b0;
                if (out_valid_o && out_ready_i) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_output: tag %h result %h with empty scoreboard", tag_o, result_o);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", result_o, e.res);
                        check("fflags", DW'(fflags_o), DW'(e.ff));
                        check("tag", DW'(tag_o), DW'(e.tag));
                        if (e.lat) check("latency", DW'(cyc - e.cyc), DW'(2));
                    end
                end else if (out_valid_o) begin
                    stalled = 1'b1;
                    h_res = result_o; h_ff = fflags_o; h_tag = tag_o;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        op_i = '0; a_i = '0; b_i = '0; lane_mask_i = '0; tag_i = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", DW'(out_valid_o), DW'(0));
        check("rst_result", result_o, '0);
        check("rst_fflags", DW'(fflags_o), DW'(0));
        check("rst_tag", DW'(tag_o), DW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", DW'(in_ready_o), DW'(1));
        @(negedge clk);

        // EQ: -0 == +0, equal, unequal, sign differs
        send(3'b000, {32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h80000000},
                     {32'h3F800000, 32'h40000000, 32'h3F800000, 32'h00000000}, 4'hF, 8'h01,
                     {32'h0, 32'h0, 32'h1, 32'h1}, 5'h00, 1'b1);
        // LE: negative ordering
        send(3'b001, {32'h40000000, 32'hBF800000, 32'hC0000000, 32'hBF800000},
                     {32'h40000000, 32'hC0000000, 32'hBF800000, 32'h3F800000}, 4'hF, 8'h02,
                     {32'h1, 32'h0, 32'h1, 32'h1}, 5'h00, 1'b1);
        // LT: sNaN raises invalid; +0 < -0 false
        send(3'b010, {32'h40000000, 32'h3F800000, 32'h00000000, 32'h7FA00000},
                     {32'h40000000, 32'h40000000, 32'h80000000, 32'h3F800000}, 4'hF, 8'h03,
                     {32'h0, 32'h1, 32'h0, 32'h0}, 5'h10, 1'b1);
        // EQ with qNaN: quiet
        send(3'b000, {32'h00000000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000},
                     {32'h00000000, 32'h3F800000, 32'h7FC00000, 32'h3F800000}, 4'hF, 8'h04,
                     {32'h1, 32'h1, 32'h0, 32'h0}, 5'h00, 1'b1);
        // LT with qNaN in b: invalid
        send(3'b010, {32'h00800000, 32'hC0000000, 32'h80000000, 32'h3F800000},
                     {32'h00000000, 32'hBF800000, 32'h00000000, 32'hFFC00000}, 4'hF, 8'h05,
                     {32'h0, 32'h1, 32'h0, 32'h0}, 5'h10, 1'b1);
        // Masked lanes 1 and 3 (lane 1 holds sNaN)
        send(3'b000, {32'h40000000, 32'h40000000, 32'h7FA00000, 32'h3F800000},
                     {32'h40000000, 32'h40000000, 32'h7FA00000, 32'h3F800000}, 4'b0101, 8'h06,
                     {32'h0, 32'h1, 32'h0, 32'h1}, 5'h00, 1'b1);
`ifdef FCMP_PIPE_MINMAX_EN
        send(3'b011, {32'hC0000000, 32'h3F800000, 32'h00000000, 32'h7FC00000},
                     {32'hBF800000, 32'h40000000, 32'h80000000, 32'hBF800000}, 4'hF, 8'h07,
                     {32'hC0000000, 32'h3F800000, 32'h80000000, 32'hBF800000}, 5'h00, 1'b1);
        send(3'b100, {32'h7FA00000, 32'h80000000, 32'hFFC00001, 32'h7FC00000},
                     {32'h3F800000, 32'h00000000, 32'h7FE00000, 32'h7FC00000}, 4'hF, 8'h08,
                     {32'h3F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000}, 5'h10, 1'b1);
`else
        send(3'b011, {32'hC0000000, 32'h3F800000, 32'h00000000, 32'h7FA00000},
                     {32'hBF800000, 32'h40000000, 32'h80000000, 32'hBF800000}, 4'hF, 8'h07,
                     '0, 5'h00, 1'b1);
        send(3'b100, {32'h7FA00000, 32'h80000000, 32'hFFC00001, 32'h7FC00000},
                     {32'h3F800000, 32'h00000000, 32'h7FE00000, 32'h7FC00000}, 4'hF, 8'h08,
                     '0, 5'h00, 1'b1);
`endif
        for (int k = 5; k <= 7; k++) begin
            send(3'(k), {32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7FA00000},
                        {32'h3F800000, 32'h40000000, 32'h00000000, 32'h3F800000}, 4'hF, 8'(8 + k),
                        '0, 5'h00, 1'b1);
        end
        drain();

        // Back-to-back tagged stream with random downstream stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                send(3'b000, {96'h0, 32'h3F800000}, {96'h0, 32'h3F800000}, 4'hF, 8'(8'h40 + i),
                     {32'h1, 32'h1, 32'h1, 32'h1}, 5'h00, 1'b0);
            else
                send(3'b010, {96'h0, 32'h3F800000}, {96'h0, 32'h40000000}, 4'hF, 8'(8'h40 + i),
                     {32'h0, 32'h0, 32'h0, 32'h1}, 5'h00, 1'b0);
        end
        drain();

        // Reset with two requests in flight
        send(3'b000, '0, '0, 4'hF, 8'hA1, {32'h1, 32'h1, 32'h1, 32'h1}, 5'h00, 1'b0);
        send(3'b000, '0, '0, 4'hF, 8'hA2, {32'h1, 32'h1, 32'h1, 32'h1}, 5'h00, 1'b0);
        check("inflight_valid", DW'(out_valid_o), DW'(1));
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("async_rst_valid", DW'(out_valid_o), DW'(0));
        check("async_rst_result", result_o, '0);
        check("async_rst_tag", DW'(tag_o), DW'(0));
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", DW'(in_ready_o), DW'(1));
        check("post_rst_valid", DW'(out_valid_o), DW'(0));
        @(negedge clk);
        repeat (4) @(negedge clk);
        send(3'b001, {96'h0, 32'h3F800000}, {96'h0, 32'h3F800000}, 4'hF, 8'h77,
             {32'h1, 32'h1, 32'h1, 32'h1}, 5'h00, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fcmp_pipe.md
FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 SHALL have parameter EXPWIDTH, default 8, meaning exponent field width.
REQ-002 SHALL have parameter PRECISION, default 24, meaning significand width including the hidden bit.
REQ-003 SHALL have parameter LANES, default 4, meaning independent compare lanes per request.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, meaning width of the opaque sideband tag.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port in_valid_i, input, 1 bit, request valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit, request accepted when in_valid_i && in_ready_o.
REQ-009 SHALL have port op_i, input, 3 bits: 000 EQ, 001 LE, 010 LT, 011 MIN, 100 MAX.
REQ-010 SHALL have port a_i and b_i, input, LANES*(EXPWIDTH+PRECISION) bits each, packed operands with lane 0 in the LSBs.
REQ-011 SHALL have port lane_mask_i, input, LANES bits, active-lane mask.
REQ-012 SHALL have port tag_i, input, TAG_WIDTH bits, passed through unmodified.
REQ-013 SHALL have port out_valid_o, input out_ready_i, output result_o (LANES*(EXPWIDTH+PRECISION)), fflags_o (5 bits) and tag_o (TAG_WIDTH).

Function
REQ-014 SHALL implement a 2-stage pipeline: S1 registers operands plus per-lane class (zero, NaN, sNaN) and the raw unsigned subtract; S2 registers the selected result and flags.
REQ-015 SHALL present the result 2 cycles after acceptance when out_ready_i is held high, with a throughput of 1 request per cycle.
REQ-016 SHALL advance a stage when it is empty or the stage downstream advances; in_ready_o = !S1_valid || S1 advances (combinational from out_ready_i).
REQ-017 SHALL hold result_o, fflags_o and tag_o stable while out_valid_o && !out_ready_i, and SHALL never drop or duplicate a request.
REQ-018 SHALL, for EQ/LE/LT lanes, return 1 or 0 in lane bit 0 with the upper lane bits 0; +0 == -0; any NaN operand gives 0.
REQ-019 SHALL order values by sign-magnitude, so negative values are less than positive ones and larger magnitude is more negative when the sign is set.
REQ-020 SHALL raise invalid (fflags_o[4]) for EQ only on an sNaN, and for LE/LT on any NaN; fflags_o[3:0] SHALL be 0.
REQ-021 SHALL make masked-off lanes produce result 0 and contribute no flags; fflags_o is the OR over active lanes.
REQ-022 SHALL treat op codes 101..111 as reserved: every lane result 0, fflags_o 0.

Reset
REQ-023 SHALL, while rst_n is low, immediately clear both stage valids; out_valid_o=0, result_o=0, fflags_o=0 and tag_o=0.
REQ-024 SHALL, on reset asserted mid-operation, discard in-flight requests; in_ready_o=1 after the first clk edge following reset release.

Configuration
REQ-025 SHALL, with macro FCMP_PIPE_MINMAX_EN defined, implement MIN/MAX: -0 is less than +0; one NaN operand returns the other operand; two NaNs return the canonical NaN (sign 0, exponent all ones, significand MSB 1, rest 0); any sNaN raises invalid.
REQ-026 SHALL, without FCMP_PIPE_MINMAX_EN, treat op codes 011 and 100 as reserved per REQ-022 and contain no min/max datapath.

Verification
REQ-027 SHALL have a bench test: EXPWIDTH=8/PRECISION=24 with lane 0 EQ a=0x80000000, b=0x00000000 -> lane0 result 1, fflags 0x00, valid 2 cycles after acceptance.
REQ-028 SHALL have a bench test: LT with a=0x7FA00000 (sNaN) and b=0x3F800000 -> result 0, fflags 0x10; EQ with a=0x7FC00000 (qNaN) -> result 0, fflags 0x00.
REQ-029 SHALL have a bench test: MIN with macro defined, a=0x7FC00000, b=0xBF800000 -> 0xBF800000; MAX with both operands qNaN -> 0x7FC00000; MIN(+0,-0) -> 0x80000000.
REQ-030 SHALL have a bench test: back-to-back stream of 10 tagged requests with out_ready_i toggled randomly -> all 10 tags arrive in order, outputs stable while stalled.
REQ-031 SHALL have a bench test: lane_mask_i=4'b0101 with an sNaN in lane 1 -> lanes 1 and 3 return 0, fflags 0x00.
REQ-032 SHALL have a bench test: rst_n pulsed low with 2 requests in flight -> out_valid_o drops asynchronously, no stale output after release.
